// File: rtl/vm_gen_pkg.sv
// Shared types for the vending-machine controller: FSM states, status codes and coin decoding.
package vm_gen_pkg;

    typedef enum logic [1:0] {IDLE, VEND, CHANGE, FAULT} state_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_VEND    = 2'b01,
        ST_NOFUNDS = 2'b10,
        ST_SOLDOUT = 2'b11
    } status_t;

    typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_10, COIN_25} coin_t;

    function automatic logic [4:0] coin_value(coin_t c);
        unique case (c)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            COIN_25: return 5'd25;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_gen_inventory.sv
// Per-slot stock and price tables with saturating restock and a vend decrement port.
module vm_gen_inventory #(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned ITEM_W    = $clog2(NUM_ITEMS),
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned COST_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ITEM_W-1:0]  rs_item,
    input  logic [COUNT_W-1:0] rs_count,
    input  logic [COST_W-1:0]  rs_cost,
    input  logic               rs_valid,
    input  logic               dec_en,
    input  logic [ITEM_W-1:0]  dec_item,
    input  logic [ITEM_W-1:0]  rd_item,
    output logic [COUNT_W-1:0] rd_stock,
    output logic [COST_W-1:0]  rd_price,
    input  logic [ITEM_W-1:0]  sel_item,
    output logic [COST_W-1:0]  sel_price
);

    localparam logic [COUNT_W-1:0] MAX_STOCK = '1;

    logic [COUNT_W-1:0] stock_q [NUM_ITEMS];
    logic [COUNT_W-1:0] stock_d [NUM_ITEMS];
    logic [COST_W-1:0]  price_q [NUM_ITEMS];
    logic [COST_W-1:0]  price_d [NUM_ITEMS];
    logic [COUNT_W:0]   sum;

    // Out-of-range slots read as empty and free, which the FSM reports as sold out.
    assign rd_stock  = (int'(rd_item) < NUM_ITEMS) ? stock_q[rd_item] : '0;
    assign rd_price  = (int'(rd_item) < NUM_ITEMS) ? price_q[rd_item] : '0;
    assign sel_price = (int'(sel_item) < NUM_ITEMS) ? price_q[sel_item] : '0;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            price_d[i] = price_q[i];
            if (rs_valid && int'(rs_item) == i) begin
                sum        = {1'b0, stock_q[i]} + {1'b0, rs_count};
                stock_d[i] = sum[COUNT_W] ? MAX_STOCK : sum[COUNT_W-1:0];
                if (rs_cost != '0) price_d[i] = rs_cost;
            end
            // Decrement applies after saturation; a vend only happens with stock >= 1.
            if (dec_en && int'(dec_item) == i) stock_d[i] = stock_d[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= '0;
                price_q[i] <= '0;
            end
        end else begin
            stock_q <= stock_d;
            price_q <= price_d;
        end
    end

endmodule

// File: rtl/vm_gen.sv
// Vending-machine controller top: credit, vend FSM, change and status outputs (all registered).
// Define VM_GEN_KEEP_CREDIT_EN to keep leftover credit after a vend instead of auto-change.
module vm_gen
    import vm_gen_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 8,
    parameter int unsigned ITEM_W    = $clog2(NUM_ITEMS),
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned COST_W    = 8,
    parameter int unsigned BAL_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         coins,
    input  logic [ITEM_W-1:0]  buttons,
    input  logic               select,
    input  logic               cancel,
    input  logic [ITEM_W-1:0]  item,
    input  logic [COUNT_W-1:0] count,
    input  logic [COST_W-1:0]  cost,
    input  logic               valid,
    output logic [ITEM_W-1:0]  product,
    output logic               vend,
    output logic [1:0]         status,
    output logic [BAL_W-1:0]   balance,
    output logic [COST_W-1:0]  info,
    output logic [BAL_W-1:0]   change,
    output logic               change_vld
);

    localparam int unsigned BW1 = BAL_W + 1;

    state_t             state;
    logic [ITEM_W-1:0]  sel_item;
    logic [COUNT_W-1:0] rd_stock;
    logic [COST_W-1:0]  rd_price;
    logic [COST_W-1:0]  sel_price;
    logic [4:0]         cv;
    logic [BAL_W:0]     add_sum;
    logic [BAL_W:0]     vend_sum;
    logic [BAL_W-1:0]   bal_plus;
    logic [BAL_W-1:0]   bal_vend;
    logic               funds_ok;
    logic               dec_en;

    vm_gen_inventory #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_W    (ITEM_W),
        .COUNT_W   (COUNT_W),
        .COST_W    (COST_W)
    ) u_inv (
        .clk       (clk),
        .rst       (rst),
        .rs_item   (item),
        .rs_count  (count),
        .rs_cost   (cost),
        .rs_valid  (valid),
        .dec_en    (dec_en),
        .dec_item  (sel_item),
        .rd_item   (buttons),
        .rd_stock  (rd_stock),
        .rd_price  (rd_price),
        .sel_item  (sel_item),
        .sel_price (sel_price)
    );

    assign cv       = coin_value(coin_t'(coins));
    assign add_sum  = {1'b0, balance} + BW1'(cv);
    assign bal_plus = add_sum[BAL_W] ? '1 : add_sum[BAL_W-1:0];
    // Price is re-read at the VEND edge, so a mid-purchase price change is rechecked here.
    assign funds_ok = balance >= BAL_W'(sel_price);
    assign vend_sum = {1'b0, balance - BAL_W'(sel_price)} + BW1'(cv);
    assign bal_vend = vend_sum[BAL_W] ? '1 : vend_sum[BAL_W-1:0];
    assign dec_en   = (state == VEND) && funds_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel_item   <= '0;
            product    <= '0;
            vend       <= 1'b0;
            status     <= ST_IDLE;
            balance    <= '0;
            info       <= '0;
            change     <= '0;
            change_vld <= 1'b0;
        end else begin
            vend       <= 1'b0;
            change_vld <= 1'b0;
            status     <= ST_IDLE;
            info       <= rd_price;
            balance    <= bal_plus;
            case (state)
                IDLE: begin
                    if (cancel) begin
                        if (bal_plus != '0) state <= CHANGE;
                    end else if (select) begin
                        if (rd_stock == '0) begin
                            status <= ST_SOLDOUT;
                            state  <= FAULT;
                        end else if (balance < BAL_W'(rd_price)) begin
                            status <= ST_NOFUNDS;
                            state  <= FAULT;
                        end else begin
                            sel_item <= buttons;
                            state    <= VEND;
                        end
                    end
                end
                VEND: begin
                    if (funds_ok) begin
                        vend    <= 1'b1;
                        product <= sel_item;
                        status  <= ST_VEND;
                        balance <= bal_vend;
`ifdef VM_GEN_KEEP_CREDIT_EN
                        state   <= IDLE;
`else
                        state   <= (bal_vend != '0) ? CHANGE : IDLE;
`endif
                    end else begin
                        status <= ST_NOFUNDS;
                        state  <= FAULT;
                    end
                end
                CHANGE: begin
                    change     <= balance;
                    change_vld <= 1'b1;
                    balance    <= BAL_W'(cv);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_gen.sv
// Self-checking bench for vm_gen: directed scenarios plus randomized traffic against a purchase model.
module tb_vm_gen;

    localparam int N        = 8;
    localparam int BAL_MAX  = 65535;
    localparam int S_MAX    = 15;
    localparam int P_NONE   = 0;
    localparam int P_VEND   = 1;
    localparam int P_CHANGE = 2;
    localparam int P_FAULT  = 3;

    logic        clk, rst;
    logic [1:0]  coins;
    logic [2:0]  buttons;
    logic        select, cancel;
    logic [2:0]  item;
    logic [3:0]  count;
    logic [7:0]  cost;
    logic        valid;
    logic [2:0]  product;
    logic        vend;
    logic [1:0]  status;
    logic [15:0] balance;
    logic [7:0]  info;
    logic [15:0] change;
    logic        change_vld;

    int errors = 0;
    int checks = 0;

    // Purchase model: what is owed next (pending action), stock/price tables and credit.
    int m_stock [N];
    int m_price [N];
    int m_bal, m_pend, m_sel;
    int exp_vend, exp_product, exp_status, exp_balance, exp_info, exp_change, exp_cvld;

    vm_gen dut (
        .clk        (clk),
        .rst        (rst),
        .coins      (coins),
        .buttons    (buttons),
        .select     (select),
        .cancel     (cancel),
        .item       (item),
        .count      (count),
        .cost       (cost),
        .valid      (valid),
        .product    (product),
        .vend       (vend),
        .status     (status),
        .balance    (balance),
        .info       (info),
        .change     (change),
        .change_vld (change_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int x);
        return (x > BAL_MAX) ? BAL_MAX : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_stock[i] = 0;
            m_price[i] = 0;
        end
        m_bal = 0; m_pend = P_NONE; m_sel = 0;
        exp_vend = 0; exp_product = 0; exp_status = 0; exp_balance = 0;
        exp_info = 0; exp_change = 0; exp_cvld = 0;
    endtask

    task automatic model_step(input int c, input int b, input int s, input int cn,
                              input int it, input int ct, input int cs, input int v);
        int cv, dec_slot;
        dec_slot = -1;
        cv = (c == 1) ? 5 : (c == 2) ? 10 : (c == 3) ? 25 : 0;
        exp_vend = 0; exp_cvld = 0; exp_status = 0;
        exp_info = (b < N) ? m_price[b] : 0;
        case (m_pend)
            P_NONE: begin
                m_bal = sat(m_bal + cv);
                if (cn != 0) begin
                    m_pend = (m_bal != 0) ? P_CHANGE : P_NONE;
                end else if (s != 0) begin
                    if (b >= N || m_stock[b] == 0) begin
                        exp_status = 3; m_pend = P_FAULT;
                    end else if (m_bal - cv < m_price[b]) begin
                        exp_status = 2; m_pend = P_FAULT;
                    end else begin
                        m_sel = b; m_pend = P_VEND;
                    end
                end
            end
            P_VEND: begin
                if (m_bal >= m_price[m_sel]) begin
                    exp_vend = 1; exp_product = m_sel; exp_status = 1;
                    m_bal = sat(m_bal - m_price[m_sel] + cv);
                    dec_slot = m_sel;
`ifdef VM_GEN_KEEP_CREDIT_EN
                    m_pend = P_NONE;
`else
                    m_pend = (m_bal != 0) ? P_CHANGE : P_NONE;
`endif
                end else begin
                    exp_status = 2; m_pend = P_FAULT;
                    m_bal = sat(m_bal + cv);
                end
            end
            P_CHANGE: begin
                exp_change = m_bal; exp_cvld = 1;
                m_bal = cv; m_pend = P_NONE;
            end
            default: begin
                m_bal = sat(m_bal + cv); m_pend = P_NONE;
            end
        endcase
        if (v != 0) begin
            m_stock[it] = (m_stock[it] + ct > S_MAX) ? S_MAX : m_stock[it] + ct;
            if (cs != 0) m_price[it] = cs;
        end
        if (dec_slot >= 0) m_stock[dec_slot] = m_stock[dec_slot] - 1;
        exp_balance = m_bal;
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic tick(input int c, input int b, input int s, input int cn,
                        input int it, input int ct, input int cs, input int v);
        coins = 2'(c); buttons = 3'(b); select = 1'(s); cancel = 1'(cn);
        item = 3'(it); count = 4'(ct); cost = 8'(cs); valid = 1'(v);
        model_step(c, b, s, cn, it, ct, cs, v);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int b);
        tick(0, b, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        coins = '0; buttons = '0; select = 1'b0; cancel = 1'b0;
        item = '0; count = '0; cost = '0; valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (vend !== 1'b0) begin errors++; $display("FAIL reset_vend actual=%b required=0", vend); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status actual=%b required=00", status); end
        checks++; if (balance !== 16'd0) begin errors++; $display("FAIL reset_balance actual=%0d required=0", balance); end
        checks++; if (change_vld !== 1'b0 || change !== 16'd0) begin errors++; $display("FAIL reset_change actual=%b/%0d required=0/0", change_vld, change); end
        checks++; if (product !== 3'd0 || info !== 8'd0) begin errors++; $display("FAIL reset_product_info actual=%0d/%0d required=0/0", product, info); end
    endtask

    task automatic test_vend_exact();
        tick(0, 0, 0, 0, 3, 5, 35, 1);
        tick(3, 0, 0, 0, 0, 0, 0, 0);
        tick(2, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (balance !== 16'd35) begin errors++; $display("FAIL credit_35 actual=%0d required=35", balance); end
        tick(0, 3, 1, 0, 0, 0, 0, 0);
        checks++; if (vend !== 1'b0) begin errors++; $display("FAIL vend_latency actual=%b required=0", vend); end
        idle(3);
        checks++; if (vend !== 1'b1 || product !== 3'd3) begin errors++; $display("FAIL exact_vend actual=%b/%0d required=1/3", vend, product); end
        checks++; if (balance !== 16'd0 || status !== 2'b01) begin errors++; $display("FAIL exact_bal_status actual=%0d/%b required=0/01", balance, status); end
        checks++; if (dut.u_inv.stock_q[3] !== 4'd4) begin errors++; $display("FAIL exact_stock actual=%0d required=4", dut.u_inv.stock_q[3]); end
        checks++; if (info !== 8'd35) begin errors++; $display("FAIL info_price actual=%0d required=35", info); end
        idle(0);
        checks++; if (change_vld !== 1'b0 || vend !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL exact_no_change actual=%b/%b/%b required=0/0/00", change_vld, vend, status); end
    endtask

    task automatic test_nofunds();
        tick(3, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 3, 1, 0, 0, 0, 0, 0);
        checks++; if (status !== 2'b10 || balance !== 16'd30) begin errors++; $display("FAIL nofunds actual=%b/%0d required=10/30", status, balance); end
        idle(0);
        checks++; if (status !== 2'b00 || balance !== 16'd30 || vend !== 1'b0) begin errors++; $display("FAIL nofunds_after actual=%b/%0d/%b required=00/30/0", status, balance, vend); end
    endtask

    task automatic test_soldout();
        tick(2, 0, 0, 0, 0, 0, 0, 0);
        tick(2, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 6, 1, 0, 0, 0, 0, 0);
        checks++; if (status !== 2'b11 || balance !== 16'd50) begin errors++; $display("FAIL soldout actual=%b/%0d required=11/50", status, balance); end
        idle(0);
        checks++; if (vend !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL soldout_after actual=%b/%b required=0/00", vend, status); end
    endtask

    task automatic test_change();
        tick(0, 3, 1, 0, 0, 0, 0, 0);
        idle(0);
        checks++; if (vend !== 1'b1 || balance !== 16'd15) begin errors++; $display("FAIL change_vend actual=%b/%0d required=1/15", vend, balance); end
        idle(0);
`ifdef VM_GEN_KEEP_CREDIT_EN
        checks++; if (change_vld !== 1'b0 || balance !== 16'd15) begin errors++; $display("FAIL keep_credit actual=%b/%0d required=0/15", change_vld, balance); end
`else
        checks++; if (change_vld !== 1'b1 || change !== 16'd15 || balance !== 16'd0) begin errors++; $display("FAIL auto_change actual=%b/%0d/%0d required=1/15/0", change_vld, change, balance); end
        idle(0);
        checks++; if (change_vld !== 1'b0) begin errors++; $display("FAIL change_pulse actual=%b required=0", change_vld); end
`endif
    endtask

    task automatic test_cancel();
        do_reset();
        tick(3, 0, 0, 0, 0, 0, 0, 0);
        tick(2, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 3, 1, 1, 0, 0, 0, 0);
        checks++; if (vend !== 1'b0 || status !== 2'b00) begin errors++; $display("FAIL cancel_wins actual=%b/%b required=0/00", vend, status); end
        idle(0);
        checks++; if (change_vld !== 1'b1 || change !== 16'd40 || balance !== 16'd0) begin errors++; $display("FAIL cancel_change actual=%b/%0d/%0d required=1/40/0", change_vld, change, balance); end
    endtask

    task automatic test_saturate();
        tick(0, 0, 0, 0, 2, 10, 20, 1);
        tick(0, 0, 0, 0, 2, 15, 0, 1);
        checks++; if (dut.u_inv.stock_q[2] !== 4'd15) begin errors++; $display("FAIL stock_sat actual=%0d required=15", dut.u_inv.stock_q[2]); end
        idle(2);
        checks++; if (info !== 8'd20) begin errors++; $display("FAIL price_keep actual=%0d required=20", info); end
    endtask

    task automatic test_same_edge();
        tick(0, 0, 0, 0, 3, 4, 35, 1);
        tick(3, 0, 0, 0, 0, 0, 0, 0);
        tick(2, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 3, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 3, 2, 0, 1);
        checks++; if (vend !== 1'b1 || dut.u_inv.stock_q[3] !== 4'd5) begin errors++; $display("FAIL same_edge actual=%b/%0d required=1/5", vend, dut.u_inv.stock_q[3]); end
    endtask

    task automatic test_reset_mid_vend();
        tick(3, 0, 0, 0, 0, 0, 0, 0);
        tick(3, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 3, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        checks++; if (balance !== 16'd0 || status !== 2'b00 || product !== 3'd0 || info !== 8'd0) begin errors++; $display("FAIL midreset_async actual=%0d/%b/%0d/%0d required=0/00/0/0", balance, status, product, info); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(0);
        checks++; if (vend !== 1'b0 || balance !== 16'd0 || dut.u_inv.stock_q[3] !== 4'd0) begin errors++; $display("FAIL midreset_abort actual=%b/%0d/%0d required=0/0/0", vend, balance, dut.u_inv.stock_q[3]); end
    endtask

    task automatic test_random();
        int c, b, s, cn, it, ct, cs, v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            c  = int'($urandom_range(0, 3));
            b  = int'($urandom_range(0, N - 1));
            s  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            cn = ($urandom_range(0, 29) == 0) ? 1 : 0;
            v  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            it = int'($urandom_range(0, N - 1));
            ct = int'($urandom_range(0, 15));
            cs = ($urandom_range(0, 2) == 0) ? 0 : 5 * int'($urandom_range(1, 12));
            tick(c, b, s, cn, it, ct, cs, v);
            checks++; if (vend !== 1'(exp_vend)) begin errors++; $display("FAIL rnd_vend cyc=%0d actual=%b required=%0d", n, vend, exp_vend); end
            checks++; if (product !== 3'(exp_product)) begin errors++; $display("FAIL rnd_product cyc=%0d actual=%0d required=%0d", n, product, exp_product); end
            checks++; if (status !== 2'(exp_status)) begin errors++; $display("FAIL rnd_status cyc=%0d actual=%b required=%0d", n, status, exp_status); end
            checks++; if (balance !== 16'(exp_balance)) begin errors++; $display("FAIL rnd_balance cyc=%0d actual=%0d required=%0d", n, balance, exp_balance); end
            checks++; if (info !== 8'(exp_info)) begin errors++; $display("FAIL rnd_info cyc=%0d actual=%0d required=%0d", n, info, exp_info); end
            checks++; if (change_vld !== 1'(exp_cvld) || (exp_cvld == 1 && change !== 16'(exp_change))) begin
                errors++; $display("FAIL rnd_change cyc=%0d actual=%b/%0d required=%0d/%0d", n, change_vld, change, exp_cvld, exp_change);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_nofunds();
        test_soldout();
        test_change();
        test_cancel();
        test_saturate();
        test_same_edge();
        test_reset_mid_vend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vm_gen.md
Name: vm_gen

Overview:
- Parametrised next-generation vending-machine controller: configurable item count, stock depth, price and credit widths.
- Adds per-item stock and price tables, a vend FSM, cancel/coin-return, automatic change and sold-out/insufficient-funds status.
- Sits between the user panel (coins, buttons, select, cancel), the supplier restock port and the dispenser/coin-return mechanics.

Parameters:
- NUM_ITEMS, 8, number of product slots.
- ITEM_W, $clog2(NUM_ITEMS), item index width (derived).
- COUNT_W, 4, stock counter width per slot; stock saturates at 2**COUNT_W-1.
- COST_W, 8, price width (cents).
- BAL_W, 16, credit/balance width (cents).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- coins  in  2  coin code per cycle: 00 none, 01 = 5, 10 = 10, 11 = 25.
- buttons  in  ITEM_W  item index selected on panel.
- select  in  1  vend request for item on buttons.
- cancel  in  1  return all credit.
- item  in  ITEM_W  restock slot index.
- count  in  COUNT_W  units added to slot.
- cost  in  COST_W  new price for slot; 0 = keep existing price.
- valid  in  1  restock strobe, one transaction per cycle.
- product  out  ITEM_W  index of last vended item.
- vend  out  1  one-cycle dispense pulse.
- status  out  2  00 IDLE, 01 VEND, 10 NOFUNDS, 11 SOLDOUT.
- balance  out  BAL_W  current credit.
- info  out  COST_W  price of slot on buttons, registered (1-cycle latency).
- change  out  BAL_W  change amount, valid with change_vld.
- change_vld  out  1  one-cycle change pulse.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; stock[] and price[] 0.
- All outputs registered; no combinational input-to-output path.
- Coins accepted in every state. Coin value is added on the same edge as any other balance update and saturates at 2**BAL_W-1.
- Restock accepted in every state: stock[item] <= min(stock + count, MAX) - dec; price[item] <= cost if cost != 0.
  - dec = 1 only when a vend of the same slot occurs on that edge.
- FSM states: IDLE, VEND, CHANGE, FAULT.
- IDLE transitions:
  - cancel=1: go to CHANGE if balance + coin != 0, else stay. cancel wins over select.
  - select=1, stock[buttons]==0: go to FAULT, status <= SOLDOUT.
  - select=1, balance < price[buttons]: go to FAULT, status <= NOFUNDS.
  - select=1 otherwise: latch sel_item <= buttons, go to VEND.
  - Stock and price are checked against the values before any same-edge restock.
- VEND (one cycle):
  - vend <= 1; product <= sel_item; status <= VEND.
  - balance <= balance - price[sel_item] + coin; stock[sel_item] decrements.
  - Next state CHANGE if the remaining balance != 0, else IDLE.
  - price[sel_item] is the value at the VEND edge; a price change between select and VEND is honoured only if funds still cover it, else go to FAULT/NOFUNDS.
- CHANGE (one cycle):
  - change <= balance; change_vld <= 1; balance <= coin (value of the coin arriving that cycle); go to IDLE.
- FAULT (one cycle): status holds the fault code, balance unchanged, then IDLE with status <= IDLE.
- Latency: select sampled at edge k; vend, product and balance update at edge k+1; change_vld at edge k+2.
- Reset mid-vend: the vend is aborted and credit is lost; this is the required behaviour.
- buttons index >= NUM_ITEMS is treated as SOLDOUT.

Optional Feature:
- Macro VM_GEN_KEEP_CREDIT_EN.
- Defined: VEND always returns to IDLE and the remaining credit is retained for further purchases. Change is issued only on cancel.
- Undefined: auto-change after VEND as described above.

Decomposition:
- Package vm_gen_pkg holds:
  - enum state_t {IDLE, VEND, CHANGE, FAULT};
  - enum status_t {ST_IDLE=2'b00, ST_VEND=2'b01, ST_NOFUNDS=2'b10, ST_SOLDOUT=2'b11};
  - enum coin_t and function coin_value(coin_t) returning 0/5/10/25.
- Sub-module vm_gen_inventory holds the stock/price arrays, restock saturation and the decrement port, with combinational read of slot stock/price.

Test Plan:
- Restock item=3, count=5, cost=35; coins 25 then 10; select buttons=3 -> vend=1, product=3, balance 0, stock[3]=4, no change_vld.
- Balance 30; select item 3 (price 35) -> status=NOFUNDS for one cycle, balance stays 30, then status=IDLE.
- Select empty slot 6 with balance 50 -> status=SOLDOUT, no vend, balance 50.
- Balance 50, buy item 3 -> vend, then change=15 with change_vld; with VM_GEN_KEEP_CREDIT_EN -> balance 15, no change_vld.
- Balance 40, cancel and select together -> change=40, no vend. Restock item 2 with count=15 on top of stock 10 -> stock[2]=15 (saturated).
- Same-edge restock of item 3 (count=2) during VEND of item 3 with stock 4 -> stock 5; rst low mid-VEND -> all outputs 0 immediately.
